down_timer: RTL and testbench

Programmable one-shot down-counting timer, the count-down counterpart of the team's synchronous up-counters. A start request loads a value, and the count decrements on every enabled tick. A single-cycle terminal-count pulse fires when the count reaches zero. The block sits beside the up-counters in the lab designs, driven by the same `en` tick (typically a prescaled clock-enable), and generates timeouts and delays for control logic.

---
 rtl/down_timer_pkg.sv | 12 +
 rtl/down_counter_core.sv | 34 +++
 rtl/down_timer.sv | 102 ++++++++++
 tb/tb_down_timer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// rtl/down_timer_pkg.sv - shared state encoding and default width for down_timer
package down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_counter_core.sv
// rtl/down_counter_core.sv - loadable down-counter datapath with is_one flag
module down_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             dec,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             is_one
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // clr beats ld beats dec; decrement wraps modulo 2^WIDTH
  always_comb begin
    q_d = q_q;
    if (clr)      q_d = '0;
    else if (ld)  q_d = d;
    else if (dec) q_d = q_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q      = q_q;
  assign is_one = (q_q == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/down_timer.sv
// rtl/down_timer.sv - one-shot down timer FSM; DOWN_TIMER_AUTORELOAD_EN makes it periodic
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  state_t           state_q, state_d;
  logic             busy_q, tc_q, tc_d;
  logic             ld, dec, clr, is_one;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] reload_val;

`ifdef DOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] shadow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      shadow_q <= '0;
    else if (state_q != RUN && start && !stop)    shadow_q <= load;
  end

  assign reload_val = shadow_q;
`else
  assign reload_val = '0;
`endif

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    dec     = 1'b0;
    clr     = 1'b0;
    ld_val  = load;
    tc_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start && !stop) begin
          ld      = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          clr     = 1'b1;
          state_d = IDLE;
        end else if (en) begin
          if (is_one) begin
            tc_d = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
            ld     = 1'b1;
            ld_val = reload_val;
`else
            dec     = 1'b1;
            state_d = DONE;
`endif
          end else begin
            dec = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      tc_q    <= tc_d;
    end
  end

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld),
    .dec    (dec),
    .clr    (clr),
    .d      (ld_val),
    .q      (count),
    .is_one (is_one)
  );

  assign busy = busy_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// tb/tb_down_timer.sv - directed plus random checks of down_timer against a tick-budget model
module tb_down_timer;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst, en, start, stop;
  logic [W-1:0] load;
  logic [W-1:0] count;
  logic         busy, tc;

  int checks   = 0;
  int failures = 0;

`ifdef DOWN_TIMER_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  // Model: a run is a budget of enabled ticks; count is the budget modulo 2^W
  bit m_run;
  int m_rem, m_per, m_cnt;
  bit m_tc;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .stop  (stop),
    .load  (load),
    .count (count),
    .busy  (busy),
    .tc    (tc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_rem = 0; m_per = 0; m_cnt = 0; m_tc = 1'b0;
  endtask

  task automatic model_edge();
    m_tc = 1'b0;
    if (m_run) begin
      if (stop) begin
        m_run = 1'b0;
        m_cnt = 0;
      end else if (en) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_tc = 1'b1;
          if (AUTORELOAD) begin
            m_rem = m_per;
            m_cnt = m_per % M;
          end else begin
            m_run = 1'b0;
            m_cnt = 0;
          end
        end else begin
          m_cnt = m_rem % M;
        end
      end
    end else if (start && !stop) begin
      m_run = 1'b1;
      m_per = (load == 0) ? M : int'(load);
      m_rem = m_per;
      m_cnt = int'(load);
    end
  endtask

  task automatic check_outputs(input string what);
    chk({what, ".count"}, {28'd0, count}, m_cnt);
    chk({what, ".busy"},  {31'd0, busy},  {31'd0, m_run});
    chk({what, ".tc"},    {31'd0, tc},    {31'd0, m_tc});
  endtask

  task automatic step(input bit e, input bit s, input bit p, input int ld);
    en = e; start = s; stop = p; load = ld[W-1:0];
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("step");
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; load = '0;
    model_reset();
    #2;
    check_outputs("por");
    chk("por.count0", {28'd0, count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // load=5, en held high, then idle afterwards
    step(1, 1, 0, 5);
    repeat (7) step(1, 0, 0, 0);

    // load=0 is a full 2^W period
    step(1, 1, 0, 0);
    repeat (18) step(1, 0, 0, 0);

    // load=3 with en toggling
    step(1, 1, 0, 3);
    for (int i = 0; i < 9; i++) step((i % 2) == 1, 0, 0, 0);

    // stop at count=2 together with en
    step(1, 1, 0, 4);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);

    // async reset mid-run with count=4
    step(1, 1, 0, 6);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    async_reset();
    step(1, 0, 0, 0);

    // start ignored in RUN; restart during DONE with no gap
    step(1, 1, 0, 5);
    step(1, 1, 0, 7);
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 0, 2);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 2);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);

    // start with stop in IDLE is ignored; stop in IDLE is harmless
    step(1, 1, 1, 3);
    step(1, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 19) == 0, int'($urandom_range(0, M - 1)));
      end
    end

    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
